// File: rtl/trace_cache_sim_pkg.sv
// Shared definitions for the trace cache model: FSM encodings and statistics
// counter width / saturation value.
package trace_cache_sim_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_FILL   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam int              CNT_W   = 32;
   localparam logic [CNT_W-1:0] CNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/trace_cache_sim_tag_array.sv
// Valid + tag storage for the direct-mapped cache model. One combinational
// read port, one write port, and a synchronous clear of every valid bit.
module cache_tag_array
   import trace_cache_sim_pkg::*;
#(
   parameter int IDX_W = 6,
   parameter int TAG_W = 22
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_mem [LINES];

   // Valid bits: clear-all has priority over a line write.
   always_ff @(posedge clk) begin
      if (clr)
         valid_q <= '0;
      else if (we)
         valid_q[wr_idx] <= 1'b1;
   end

   // Tag storage is plain data; only meaningful where the valid bit is set.
   always_ff @(posedge clk) begin
      if (we)
         tag_mem[wr_idx] <= wr_tag;
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];

endmodule

// File: rtl/trace_cache_sim.sv
// Direct-mapped cache tag model watching a CPU address stream. Classifies
// each accepted address as hit or miss, models the miss penalty and keeps
// saturating hit/miss statistics.
module trace_cache_sim
   import trace_cache_sim_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int CACHE_BYTES  = 1024,
   parameter int BLOCK_BYTES  = 16,
   parameter int MISS_PENALTY = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic              flush_i,
   output logic              rsp_valid_o,
   output logic              rsp_hit_o,
   output logic [ADDR_W-1:0] rsp_addr_o,
   output logic [CNT_W-1:0]  hit_cnt_o,
   output logic [CNT_W-1:0]  miss_cnt_o
);

   localparam int OFF_W = $clog2(BLOCK_BYTES);
   localparam int IDX_W = $clog2(CACHE_BYTES / BLOCK_BYTES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int PEN_W = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;
   localparam logic [PEN_W-1:0] PEN_LOAD = PEN_W'(MISS_PENALTY - 1);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [PEN_W-1:0]   pen_q;
   logic               rd_valid;
   logic [TAG_W-1:0]   rd_tag;
   logic               lookup_hit;
   logic               fill_done;
   logic               tag_clr;
   logic               tag_we;
   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + CNT_W'(1);
   endfunction

   assign idx         = addr_q[OFF_W +: IDX_W];
   assign tag         = addr_q[ADDR_W-1 -: TAG_W];
   assign lookup_hit  = rd_valid && (rd_tag == tag);
   assign fill_done   = (state_q == S_FILL) && (pen_q == '0);
   assign req_ready_o = (state_q == S_IDLE) && !flush_i;
   assign rsp_valid_o = (state_q == S_RESP);
   // Reset must not let an aborted fill land in the array.
   assign tag_clr     = rst_i || ((state_q == S_IDLE) && flush_i);
   assign tag_we      = fill_done && !rst_i;

   cache_tag_array #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_tags (
      .clk      (clk_i),
      .clr      (tag_clr),
      .rd_idx   (idx),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .we       (tag_we),
      .wr_idx   (idx),
      .wr_tag   (tag)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (req_valid_i && req_ready_o) state_d = S_LOOKUP;
         S_LOOKUP: state_d = lookup_hit ? S_RESP : S_FILL;
         S_FILL:   if (pen_q == '0) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Address is captured only on the handshake edge.
   always_ff @(posedge clk_i) begin
      if ((state_q == S_IDLE) && req_valid_i && req_ready_o)
         addr_q <= req_addr_i;
   end

   // Miss penalty countdown: loaded leaving LOOKUP, runs down through FILL.
   always_ff @(posedge clk_i) begin
      if (state_q == S_LOOKUP)
         pen_q <= PEN_LOAD;
      else if ((state_q == S_FILL) && (pen_q != '0))
         pen_q <= pen_q - PEN_W'(1);
   end

   // Result fields are loaded on entry to RESP and held until the next one.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_hit_o  <= 1'b0;
         rsp_addr_o <= '0;
      end else if ((state_q == S_LOOKUP) && lookup_hit) begin
         rsp_hit_o  <= 1'b1;
         rsp_addr_o <= addr_q;
      end else if (fill_done) begin
         rsp_hit_o  <= 1'b0;
         rsp_addr_o <= addr_q;
      end
   end

   // Saturating statistics, bumped once per response strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else if (state_q == S_RESP) begin
         if (rsp_hit_o)
            hit_cnt_o <= sat_inc(hit_cnt_o);
         else
            miss_cnt_o <= sat_inc(miss_cnt_o);
      end
   end

endmodule

// File: tb/tb_trace_cache_sim.sv
// Scoreboard bench for trace_cache_sim with default parameters
// (64 lines, idx=addr[9:4], tag=addr[31:10], miss penalty 4).
module tb_trace_cache_sim;

   localparam int P = 4;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [31:0] req_addr_i = '0;
   logic        flush_i = 1'b0;
   logic        rsp_valid_o;
   logic        rsp_hit_o;
   logic [31:0] rsp_addr_o;
   logic [31:0] hit_cnt_o;
   logic [31:0] miss_cnt_o;

   always #5 clk = ~clk;

   trace_cache_sim dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .flush_i     (flush_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_hit_o   (rsp_hit_o),
      .rsp_addr_o  (rsp_addr_o),
      .hit_cnt_o   (hit_cnt_o),
      .miss_cnt_o  (miss_cnt_o)
   );

   typedef struct {
      logic        hit;
      logic [31:0] addr;
      int          at;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   int   exp_hits = 0;
   int   exp_misses = 0;
   int   strobes = 0;

   // Cycle index: number of rising edges seen so far.
   always @(posedge clk) cyc++;

   // Response monitor: every strobe must match the oldest expected entry.
   always @(negedge clk) begin
      if (rsp_valid_o === 1'b1) begin
         strobes++;
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_strobe got hit=%0b addr=%h cyc=%0d, required none",
                     rsp_hit_o, rsp_addr_o, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (rsp_hit_o !== mon_e.hit || rsp_addr_o !== mon_e.addr || cyc !== mon_e.at)
               $display("FAIL rsp got hit=%0b addr=%h cyc=%0d, required hit=%0b addr=%h cyc=%0d",
                        rsp_hit_o, rsp_addr_o, cyc, mon_e.hit, mon_e.addr, mon_e.at);
            else
               passes++;
         end
      end
   end

   // Called at a falling edge with the bench idle.
   task automatic apply_reset();
      rst_i = 1'b1;
      req_valid_i = 1'b0;
      flush_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_i = 1'b0;
      sb.delete();
      exp_hits = 0;
      exp_misses = 0;
      @(negedge clk);
   endtask

   // Present a request at a falling edge; push its expected result on acceptance.
   task automatic do_req(input logic [31:0] a, input logic h);
      int n;
      req_valid_i = 1'b1;
      req_addr_i  = a;
      #1;
      n = 0;
      while (req_ready_o !== 1'b1 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 50) begin
         $display("FAIL accept_timeout addr=%h ready=%b, required ready=1", a, req_ready_o);
      end else begin
         passes++;
         sb.push_back('{h, a, cyc + 2 + (h ? 0 : P)});
         if (h) exp_hits++; else exp_misses++;
      end
      @(posedge clk);
      #1 req_valid_i = 1'b0;
   endtask

   // Wait (bounded) until every expected response has been seen.
   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         $display("FAIL rsp_timeout pending=%0d, required 0", sb.size());
         sb.delete();
      end else begin
         passes++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (req_ready_o !== 1'b1) $display("FAIL reset_ready got %b, required 1", req_ready_o);
      else passes++;
      checks++;
      if (rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid got %b, required 0", rsp_valid_o);
      else passes++;
      checks++;
      if (rsp_hit_o !== 1'b0 || rsp_addr_o !== 32'h0)
         $display("FAIL reset_rsp got hit=%b addr=%h, required 0/0", rsp_hit_o, rsp_addr_o);
      else passes++;
      checks++;
      if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0)
         $display("FAIL reset_cnt got %0d/%0d, required 0/0", hit_cnt_o, miss_cnt_o);
      else passes++;
   endtask

   task automatic test_cold_miss_hit();
      do_req(32'h0000_0000, 1'b0);
      drain();
      checks++;
      if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd0)
         $display("FAIL cold_cnt got hit=%0d miss=%0d, required 0/1", hit_cnt_o, miss_cnt_o);
      else passes++;
      do_req(32'h0000_0000, 1'b1);
      drain();
      checks++;
      if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd1)
         $display("FAIL rehit_cnt got hit=%0d miss=%0d, required 1/1", hit_cnt_o, miss_cnt_o);
      else passes++;
      checks++;
      if (rsp_hit_o !== 1'b1) $display("FAIL hit_hold got %b, required 1", rsp_hit_o);
      else passes++;
   endtask

   task automatic test_same_line();
      apply_reset();
      do_req(32'h0000_0040, 1'b0);
      drain();
      do_req(32'h0000_004C, 1'b1);
      drain();
      do_req(32'h0000_0050, 1'b0);
      drain();
      checks++;
      if (hit_cnt_o !== 32'd1 || miss_cnt_o !== 32'd2)
         $display("FAIL same_line_cnt got hit=%0d miss=%0d, required 1/2", hit_cnt_o, miss_cnt_o);
      else passes++;
      checks++;
      if (rsp_hit_o !== 1'b0 || rsp_addr_o !== 32'h0000_0050)
         $display("FAIL rsp_hold got hit=%b addr=%h, required 0/00000050", rsp_hit_o, rsp_addr_o);
      else passes++;
   endtask

   task automatic test_conflict();
      apply_reset();
      do_req(32'h0000_0000, 1'b0);
      drain();
      do_req(32'h0000_0400, 1'b0);
      drain();
      do_req(32'h0000_0000, 1'b0);
      drain();
      checks++;
      if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd3)
         $display("FAIL conflict_cnt got hit=%0d miss=%0d, required 0/3", hit_cnt_o, miss_cnt_o);
      else passes++;
   endtask

   task automatic test_flush();
      apply_reset();
      do_req(32'h0000_0020, 1'b0);
      drain();
      flush_i = 1'b1;
      req_valid_i = 1'b1;
      req_addr_i = 32'h0000_0020;
      #1;
      checks++;
      if (req_ready_o !== 1'b0) $display("FAIL flush_ready got %b, required 0", req_ready_o);
      else passes++;
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      checks++;
      if (req_ready_o !== 1'b1) $display("FAIL post_flush_ready got %b, required 1", req_ready_o);
      else passes++;
      do_req(32'h0000_0020, 1'b0);
      drain();
      checks++;
      if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd2)
         $display("FAIL flush_cnt got hit=%0d miss=%0d, required 0/2", hit_cnt_o, miss_cnt_o);
      else passes++;
   endtask

   task automatic test_reset_mid_fill();
      apply_reset();
      req_valid_i = 1'b1;
      req_addr_i = 32'h0000_1000;
      #1;
      checks++;
      if (req_ready_o !== 1'b1) $display("FAIL midfill_ready got %b, required 1", req_ready_o);
      else passes++;
      @(posedge clk);                 // accept edge
      #1 req_valid_i = 1'b0;
      @(posedge clk);                 // enter first FILL cycle
      @(posedge clk);                 // enter second FILL cycle
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      exp_hits = 0;
      exp_misses = 0;
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1)
         $display("FAIL midfill_state got rsp_valid=%b ready=%b, required 0/1", rsp_valid_o, req_ready_o);
      else passes++;
      checks++;
      if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0)
         $display("FAIL midfill_cnt got %0d/%0d, required 0/0", hit_cnt_o, miss_cnt_o);
      else passes++;
      repeat (8) @(negedge clk);
      do_req(32'h0000_1000, 1'b0);
      drain();
      checks++;
      if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd1)
         $display("FAIL refill_cnt got hit=%0d miss=%0d, required 0/1", hit_cnt_o, miss_cnt_o);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int accepts;
      int s0;
      apply_reset();
      do_req(32'h0000_0080, 1'b0);
      drain();
      s0 = strobes;
      accepts = 0;
      req_valid_i = 1'b1;
      req_addr_i = 32'h0000_0080;
      #1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (req_ready_o !== ((i % 3) == 0))
            $display("FAIL held_ready[%0d] got %b, required %b", i, req_ready_o, ((i % 3) == 0));
         else passes++;
         if (req_ready_o === 1'b1) begin
            sb.push_back('{1'b1, 32'h0000_0080, cyc + 2});
            exp_hits++;
            accepts++;
         end
         @(negedge clk);
         #1;
      end
      req_valid_i = 1'b0;
      drain();
      checks++;
      if (accepts !== 4 || (strobes - s0) !== 4)
         $display("FAIL held_count got accepts=%0d strobes=%0d, required 4/4", accepts, strobes - s0);
      else passes++;
      checks++;
      if (hit_cnt_o !== 32'd4 || miss_cnt_o !== 32'd1)
         $display("FAIL held_cnt got hit=%0d miss=%0d, required 4/1", hit_cnt_o, miss_cnt_o);
      else passes++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_cold_miss_hit();
      test_same_line();
      test_conflict();
      test_flush();
      test_reset_mid_fill();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) $display("FAIL leftover_expected got %0d, required 0", sb.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
      $fatal(1);
   end

endmodule
